// File: rtl/sat_pkg.sv
// Shared constants for the SAT assignment sequencer: FSM encoding, LFSR setup,
// release timeout and small helper types.
package sat_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIdle    = 4'd0;
  localparam state_t StInit    = 4'd1;
  localparam state_t StPick    = 4'd2;
  localparam state_t StAssign  = 4'd3;
  localparam state_t StEval    = 4'd4;
  localparam state_t StCheck   = 4'd5;
  localparam state_t StFlip    = 4'd6;
  localparam state_t StRelease = 4'd7;
  localparam state_t StDone    = 4'd8;

  // Right-shifting Fibonacci LFSR; taps 16,14,13,11 sit at bit positions 0,2,3,5.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'h002D;

  localparam int unsigned ReleaseTimeout = 256;
  localparam int unsigned TimerW         = $clog2(ReleaseTimeout);

  typedef struct packed {
    logic busy;
    logic sat;
    logic unsat;
  } status_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = ^(s & LfsrTaps);
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/trail_stack.sv
// Decision trail: a LIFO of {variable index, flipped} entries with a stack
// pointer that may equal Depth when every variable has been decided.
module trail_stack #(
  parameter int unsigned Depth = 16,
  parameter int unsigned IdxW  = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [IdxW-1:0] push_idx_i,
  input  logic            pop_i,
  input  logic            set_flip_i,
  output logic [IdxW-1:0] top_idx_o,
  output logic            top_flipped_o,
  output logic [IdxW:0]   sp_o
);

  logic [IdxW-1:0] idx_q  [Depth];
  logic            flip_q [Depth];
  logic [IdxW:0]   sp_q, sp_d;
  logic [IdxW-1:0] top_ptr;
  logic            full, empty;

  assign full    = (sp_q == (IdxW+1)'(Depth));
  assign empty   = (sp_q == '0);
  assign top_ptr = sp_q[IdxW-1:0] - IdxW'(1);

  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i && !full) begin
      sp_d = sp_q + (IdxW+1)'(1);
    end else if (pop_i && !empty) begin
      sp_d = sp_q - (IdxW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entries above sp are never read, so storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full && !clear_i) begin
      idx_q[sp_q[IdxW-1:0]]  <= push_idx_i;
      flip_q[sp_q[IdxW-1:0]] <= 1'b0;
    end else if (set_flip_i && !empty) begin
      flip_q[top_ptr] <= 1'b1;
    end
  end

  assign top_idx_o     = idx_q[top_ptr];
  assign top_flipped_o = flip_q[top_ptr];
  assign sp_o          = sp_q;

endmodule

// File: rtl/assign_sequencer.sv
// Chronological-backtracking decision sequencer: picks the lowest unassigned
// variable, evaluates, flips on conflict and unwinds the trail until SAT/UNSAT.
module assign_sequencer
  import sat_pkg::*;
#(
  parameter int unsigned NVAR = 16,
  parameter int unsigned IDXW = $clog2(NVAR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NVAR-1:0] vout_p,
  input  logic [NVAR-1:0] vout_n,
  input  logic [NVAR-1:0] back,
  input  logic            eval_done,
  input  logic            conflict,
  output logic            reset_fire,
  output logic [NVAR-1:0] assign_fire,
  output logic [NVAR-1:0] complement_fire,
  output logic            evaluate_fire,
  output logic            random_digit,
  output logic            busy,
  output logic            sat,
  output logic            unsat
);

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic [IDXW-1:0]   cur_idx_q, cur_idx_d;
  logic [IDXW-1:0]   rel_idx_q, rel_idx_d;
  logic              conflict_q, conflict_d;
  logic [TimerW-1:0] timer_q, timer_d;
  status_t           status_q, status_d;

  logic              reset_fire_q, reset_fire_d;
  logic              evaluate_fire_q, evaluate_fire_d;
  logic              random_digit_q, random_digit_d;
  logic [NVAR-1:0]   assign_fire_q, assign_fire_d;
  logic [NVAR-1:0]   complement_fire_q, complement_fire_d;

  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic              push, pop, set_flip, clear;
  logic [IDXW-1:0]   top_idx;
  logic              top_flipped;
  logic [IDXW:0]     sp;
  logic              sp_empty;

  assign sp_empty = (sp == '0);

  trail_stack #(
    .Depth (NVAR),
    .IdxW  (IDXW)
  ) u_trail (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .push_i        (push),
    .push_idx_i    (cur_idx_q),
    .pop_i         (pop),
    .set_flip_i    (set_flip),
    .top_idx_o     (top_idx),
    .top_flipped_o (top_flipped),
    .sp_o          (sp)
  );

  // Lowest-index unassigned variable wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = int'(NVAR) - 1; k >= 0; k--) begin
      if (!(vout_p[k] | vout_n[k])) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    rel_idx_d  = rel_idx_q;
    conflict_d = conflict_q;
    timer_d    = timer_q;
    status_d   = status_q;
    push       = 1'b0;
    pop        = 1'b0;
    set_flip   = 1'b0;
    clear      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d        = StInit;
          status_d.busy  = 1'b1;
          status_d.sat   = 1'b0;
          status_d.unsat = 1'b0;
        end
      end
      StInit: begin
        clear   = 1'b1;
        state_d = StPick;
      end
      StPick: begin
        if (pick_found) begin
          cur_idx_d = pick_idx;
          state_d   = StAssign;
        end else begin
          state_d       = StDone;
          status_d.busy = 1'b0;
          status_d.sat  = 1'b1;
        end
      end
      StAssign: begin
        push    = 1'b1;
        state_d = StEval;
      end
      StEval: begin
        if (eval_done) begin
          conflict_d = conflict;
          state_d    = StCheck;
        end
      end
      StCheck: begin
        if (!conflict_q) begin
          state_d = StPick;
        end else if (sp_empty) begin
          state_d        = StDone;
          status_d.busy  = 1'b0;
          status_d.unsat = 1'b1;
        end else if (!top_flipped) begin
          state_d = StFlip;
        end else begin
          // Pop on the way in so the wait below already sees the shorter trail.
          pop       = 1'b1;
          rel_idx_d = top_idx;
          timer_d   = '0;
          state_d   = StRelease;
        end
      end
      StFlip: begin
        set_flip = 1'b1;
        state_d  = StEval;
      end
      StRelease: begin
        if (back[rel_idx_q]) begin
          if (sp_empty) begin
            state_d        = StDone;
            status_d.busy  = 1'b0;
            status_d.unsat = 1'b1;
          end else begin
            conflict_d = 1'b1;
            state_d    = StCheck;
          end
        end else if (timer_q == TimerW'(ReleaseTimeout - 1)) begin
          state_d        = StDone;
          status_d.busy  = 1'b0;
          status_d.unsat = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Fire outputs are registered off the next state so each lands in the
  // single cycle its state is occupied (evaluate only on EVAL entry).
  always_comb begin
    reset_fire_d      = (state_d == StInit);
    assign_fire_d     = (state_d == StAssign) ? (NVAR'(1) << cur_idx_d) : '0;
    complement_fire_d = (state_d == StFlip) ? (NVAR'(1) << top_idx) : '0;
    evaluate_fire_d   = (state_d == StEval) && (state_q != StEval);
    random_digit_d    = (state_d == StAssign) ? lfsr_q[0] : random_digit_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      lfsr_q            <= LfsrSeed;
      cur_idx_q         <= '0;
      rel_idx_q         <= '0;
      conflict_q        <= 1'b0;
      timer_q           <= '0;
      status_q          <= '0;
      reset_fire_q      <= 1'b0;
      evaluate_fire_q   <= 1'b0;
      random_digit_q    <= 1'b0;
      assign_fire_q     <= '0;
      complement_fire_q <= '0;
    end else begin
      state_q           <= state_d;
      lfsr_q            <= lfsr_step(lfsr_q);
      cur_idx_q         <= cur_idx_d;
      rel_idx_q         <= rel_idx_d;
      conflict_q        <= conflict_d;
      timer_q           <= timer_d;
      status_q          <= status_d;
      reset_fire_q      <= reset_fire_d;
      evaluate_fire_q   <= evaluate_fire_d;
      random_digit_q    <= random_digit_d;
      assign_fire_q     <= assign_fire_d;
      complement_fire_q <= complement_fire_d;
    end
  end

  assign reset_fire      = reset_fire_q;
  assign assign_fire     = assign_fire_q;
  assign complement_fire = complement_fire_q;
  assign evaluate_fire   = evaluate_fire_q;
  assign random_digit    = random_digit_q;
  assign busy            = status_q.busy;
  assign sat             = status_q.sat;
  assign unsat           = status_q.unsat;

endmodule

// File: tb/tb_assign_sequencer.sv
// Scoreboard bench for assign_sequencer (NVAR=4): directed solves queue the
// expected fire pulses, a negedge monitor pops and compares them.
module tb_assign_sequencer;

  localparam int unsigned NVAR = 4;
  localparam int unsigned IDXW = 2;

  // kind: 0 reset_fire, 1 assign_fire, 2 complement_fire, 3 evaluate_fire
  typedef struct packed {
    logic [1:0]      kind;
    logic [IDXW-1:0] idx;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            eval_done = 1'b0;
  logic            conflict = 1'b0;
  logic            back_en = 1'b1;
  logic [NVAR-1:0] vout_p = '0;
  logic [NVAR-1:0] vout_n = '0;
  logic [NVAR-1:0] back;
  logic            reset_fire, evaluate_fire, random_digit, busy, sat, unsat;
  logic [NVAR-1:0] assign_fire, complement_fire;

  int   n_vec = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  ev_t  mon_got, mon_want;
  int   mon_nf;
  logic [15:0] m_lfsr, m_lfsr_prev;

  assign back = {NVAR{back_en}};

  always #5 clk = ~clk;

  assign_sequencer #(
    .NVAR (NVAR),
    .IDXW (IDXW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .vout_p          (vout_p),
    .vout_n          (vout_n),
    .back            (back),
    .eval_done       (eval_done),
    .conflict        (conflict),
    .reset_fire      (reset_fire),
    .assign_fire     (assign_fire),
    .complement_fire (complement_fire),
    .evaluate_fire   (evaluate_fire),
    .random_digit    (random_digit),
    .busy            (busy),
    .sat             (sat),
    .unsat           (unsat)
  );

  // Reference LFSR written in the classic shift/xor software form.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic logic [IDXW-1:0] enc(input logic [NVAR-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int k = 0; k < int'(NVAR); k++) if (v[k]) r = IDXW'(k);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= ref_lfsr(m_lfsr);
  end

  // Assignment-unit model driven by the fire pulses.
  always @(posedge clk) begin
    if (reset_fire) begin
      vout_p <= '0;
      vout_n <= '0;
    end else begin
      for (int k = 0; k < int'(NVAR); k++) begin
        if (assign_fire[k]) begin
          vout_p[k] <= random_digit;
          vout_n[k] <= !random_digit;
        end
        if (complement_fire[k]) begin
          vout_p[k] <= vout_n[k];
          vout_n[k] <= vout_p[k];
        end
      end
    end
  end

  // Monitor: one-hot fire check, scoreboard pop, polarity check on assigns.
  always @(negedge clk) begin
    mon_nf = int'(reset_fire) + int'(evaluate_fire) + $countones(assign_fire)
           + $countones(complement_fire);
    if (mon_nf > 0) begin
      n_vec++;
      if (mon_nf > 1) begin
        n_bad++;
        $display("FAIL fire_onehot t=%0t got %0d fires high, want 1", $time, mon_nf);
      end else begin
        if (reset_fire)         mon_got = '{kind: 2'd0, idx: '0};
        else if (evaluate_fire) mon_got = '{kind: 2'd3, idx: '0};
        else if (assign_fire != '0) mon_got = '{kind: 2'd1, idx: enc(assign_fire)};
        else                    mon_got = '{kind: 2'd2, idx: enc(complement_fire)};
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL event t=%0t got kind%0d idx%0d, want no event", $time,
                   mon_got.kind, mon_got.idx);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got != mon_want) begin
            n_bad++;
            $display("FAIL event t=%0t got kind%0d idx%0d, want kind%0d idx%0d", $time,
                     mon_got.kind, mon_got.idx, mon_want.kind, mon_want.idx);
          end
        end
        if (assign_fire != '0) begin
          n_vec++;
          if (random_digit !== m_lfsr_prev[0]) begin
            n_bad++;
            $display("FAIL random_digit t=%0t got %0b want %0b", $time, random_digit,
                     m_lfsr_prev[0]);
          end
        end
      end
    end
    m_lfsr_prev = m_lfsr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic ev(input logic [1:0] kind, input int idx);
    exp_q.push_back('{kind: kind, idx: IDXW'(idx)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_eval_fire();
    int n;
    n = 0;
    while (!evaluate_fire && n < 100) begin
      tick();
      n++;
    end
    if (!evaluate_fire) begin
      n_vec++;
      n_bad++;
      $display("FAIL eval_wait got no evaluate_fire want one within 100 cycles");
    end
  endtask

  // Answers one evaluation; returns in the CHECK cycle that follows it.
  task automatic do_eval(input logic c);
    wait_eval_fire();
    tick();
    eval_done = 1'b1;
    conflict  = c;
    tick();
    eval_done = 1'b0;
    conflict  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_wait got busy=1 want busy=0 within 1000 cycles");
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat_unsat", {30'd0, sat, unsat}, 32'd0);
    chk("rst_fires", {22'd0, assign_fire, complement_fire, reset_fire, evaluate_fire}, 32'd0);
    chk("rst_sp", 32'(dut.sp), 32'd0);
    rst_n = 1'b1;
    tick();

    // eval_done while idle must not start anything
    eval_done = 1'b1;
    conflict  = 1'b1;
    tick();
    eval_done = 1'b0;
    conflict  = 1'b0;
    repeat (3) tick();
    chk("idle_eval_busy", 32'(busy), 32'd0);
    chk("idle_eval_unsat", 32'(unsat), 32'd0);

    // No conflicts: vars 0..3 in order, then SAT with a full trail
    ev(0, 0);
    for (int k = 0; k < 4; k++) begin ev(1, k); ev(3, 0); end
    pulse_start();
    for (int k = 0; k < 4; k++) do_eval(1'b0);
    wait_idle();
    chk("t1_sat", {30'd0, sat, unsat}, 32'd2);
    chk("t1_sp", 32'(dut.sp), 32'd4);
    chk("t1_queue", 32'(exp_q.size()), 32'd0);

    // First evaluation conflicts: flip var0, then carry on
    ev(0, 0); ev(1, 0); ev(3, 0); ev(2, 0); ev(3, 0);
    for (int k = 1; k < 4; k++) begin ev(1, k); ev(3, 0); end
    pulse_start();
    do_eval(1'b1);
    start = 1'b1;   // ignored outside IDLE/DONE
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) do_eval(1'b0);
    wait_idle();
    chk("t2_sat", {30'd0, sat, unsat}, 32'd2);
    chk("t2_sp", 32'(dut.sp), 32'd4);
    chk("t2_queue", 32'(exp_q.size()), 32'd0);

    // Every evaluation conflicts: assign, flip, release, UNSAT
    ev(0, 0); ev(1, 0); ev(3, 0); ev(2, 0); ev(3, 0);
    pulse_start();
    do_eval(1'b1);
    do_eval(1'b1);
    wait_idle();
    chk("t3_unsat", {30'd0, sat, unsat}, 32'd1);
    chk("t3_sp", 32'(dut.sp), 32'd0);
    chk("t3_queue", 32'(exp_q.size()), 32'd0);

    // back withheld: CHECK cycle + 256 RELEASE cycles, unsat in the next one
    back_en = 1'b0;
    ev(0, 0); ev(1, 0); ev(3, 0); ev(2, 0); ev(3, 0);
    pulse_start();
    do_eval(1'b1);
    do_eval(1'b1);
    n = 1;
    while (!unsat && n < 400) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 32'd258);
    chk("t4_unsat", {29'd0, busy, sat, unsat}, 32'd1);
    chk("t4_queue", 32'(exp_q.size()), 32'd0);
    back_en = 1'b1;

    // Reset in EVAL, then a fresh solve re-issues reset_fire
    ev(0, 0); ev(1, 0); ev(3, 0);
    pulse_start();
    wait_eval_fire();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_status", {29'd0, busy, sat, unsat}, 32'd0);
    chk("t5_rst_fires", {22'd0, assign_fire, complement_fire, reset_fire, evaluate_fire},
        32'd0);
    chk("t5_rst_digit", 32'(random_digit), 32'd0);
    chk("t5_rst_sp", 32'(dut.sp), 32'd0);
    rst_n = 1'b1;
    tick();
    ev(0, 0);
    for (int k = 0; k < 4; k++) begin ev(1, k); ev(3, 0); end
    pulse_start();
    for (int k = 0; k < 4; k++) do_eval(1'b0);
    wait_idle();
    chk("t5_sat", {30'd0, sat, unsat}, 32'd2);
    chk("t5_sp", 32'(dut.sp), 32'd4);
    chk("t5_queue", 32'(exp_q.size()), 32'd0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want run complete");
    $fatal(1, "watchdog expired");
  end

endmodule
